// File: rtl/sparc_ifu_thr_priv_trk.sv
// Per-thread privilege tracker: TLU-written 2-bit levels, S-stage level report, flush handshake on privilege drop.
// Optional PRIV_THR_CHK_EN: flags multi-hot thr_f as a sticky error and forces that cycle's S outputs to user.

module sparc_ifu_thr_priv_lane #(
  parameter logic [1:0] RST_LEVEL = 2'b10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [1:0] wr_level,
  input  logic       flush_ack,
  output logic [1:0] level,
  output logic       flushing,
  output logic       lower
);
  typedef enum logic {IDLE, FLUSH} state_t;
  state_t state, state_nxt;

  assign lower    = wr_en && (wr_level < level);
  assign flushing = (state == FLUSH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= RST_LEVEL;
      state <= IDLE;
    end else begin
      if (wr_en) level <= wr_level;
      state <= state_nxt;
    end
  end

  // A lowering write outranks a coincident ack.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (lower) state_nxt = FLUSH;
      FLUSH:   if (!lower && flush_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
endmodule

module sparc_ifu_thr_priv_trk #(
  parameter int         NUM_THR   = 4,
  parameter logic [1:0] RST_LEVEL = 2'b10,
  localparam int        TIDW      = (NUM_THR > 1) ? $clog2(NUM_THR) : 1
) (
  input  logic                   rclk,
  input  logic                   arst_l,
  input  logic [NUM_THR-1:0]     thr_f,
  input  logic                   fetch_vld_f,
  input  logic                   tlu_wr_vld,
  input  logic [TIDW-1:0]        tlu_wr_tid,
  input  logic [1:0]             tlu_wr_level,
  input  logic [NUM_THR-1:0]     flush_ack,
  output logic                   priv_mode_s,
  output logic                   hpriv_mode_s,
  output logic                   fetch_vld_s,
  output logic [NUM_THR-1:0]     flush_req,
  output logic [2*NUM_THR-1:0]   thr_level_q,
  output logic                   thr_sel_err
);
  logic                    wr_ok;
  logic [NUM_THR-1:0]      wr_sel, flushing, lower;
  logic [NUM_THR-1:0][1:0] lvl;
  logic [TIDW-1:0]         sel_tid;
  logic                    sel_any, go;
  logic [1:0]              sel_lvl;
  logic                    priv_d, hpriv_d, fvld_d, err_d;

  // Writes of the reserved code or to a nonexistent thread are dropped.
  assign wr_ok = tlu_wr_vld && (tlu_wr_level != 2'b11) && (32'(tlu_wr_tid) < 32'(NUM_THR));

  always_comb begin
    for (int t = 0; t < NUM_THR; t++) wr_sel[t] = wr_ok && (32'(tlu_wr_tid) == 32'(t));
  end

  for (genvar t = 0; t < NUM_THR; t++) begin : g_thr
    sparc_ifu_thr_priv_lane #(.RST_LEVEL(RST_LEVEL)) u_lane (
      .clk       (rclk),
      .rst_n     (arst_l),
      .wr_en     (wr_sel[t]),
      .wr_level  (tlu_wr_level),
      .flush_ack (flush_ack[t]),
      .level     (lvl[t]),
      .flushing  (flushing[t]),
      .lower     (lower[t])
    );
  end

  assign thr_level_q = lvl;
  assign flush_req   = flushing;

  // Lowest set bit wins; bits are never merged.
  always_comb begin
    sel_tid = '0;
    sel_any = 1'b0;
    for (int t = NUM_THR - 1; t >= 0; t--) begin
      if (thr_f[t]) begin
        sel_any = 1'b1;
        sel_tid = TIDW'(t);
      end
    end
  end

  // Same-cycle write to the selected thread is bypassed onto the S outputs.
  assign sel_lvl = wr_sel[sel_tid] ? tlu_wr_level : lvl[sel_tid];
  assign go      = fetch_vld_f && sel_any;

`ifdef PRIV_THR_CHK_EN
  localparam logic [NUM_THR-1:0] THR_ONE = NUM_THR'(1);
  logic multi_hot, err_q;
  assign multi_hot   = fetch_vld_f && |(thr_f & (thr_f - THR_ONE));
  assign err_d       = err_q || multi_hot;
  assign thr_sel_err = err_q;
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) err_q <= 1'b0;
    else         err_q <= err_d;
  end
`else
  logic multi_hot;
  assign multi_hot   = 1'b0;
  assign err_d       = 1'b0;
  assign thr_sel_err = 1'b0;
`endif

  always_comb begin
    priv_d  = go && (sel_lvl != 2'b00);
    hpriv_d = go && (sel_lvl == 2'b10);
    fvld_d  = go && !(flushing[sel_tid] || lower[sel_tid]);
    if (multi_hot) begin
      priv_d  = 1'b0;
      hpriv_d = 1'b0;
      fvld_d  = 1'b0;
    end
  end

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      priv_mode_s  <= 1'b0;
      hpriv_mode_s <= 1'b0;
      fetch_vld_s  <= 1'b0;
    end else begin
      priv_mode_s  <= priv_d;
      hpriv_mode_s <= hpriv_d;
      fetch_vld_s  <= fvld_d;
    end
  end
endmodule

// File: tb/tb_sparc_ifu_thr_priv_trk.sv
// Bench for sparc_ifu_thr_priv_trk: directed table, hand sequences, and random traffic against a level/flush model.
// Build with or without PRIV_THR_CHK_EN; expectations follow the macro.

module tb_sparc_ifu_thr_priv_trk;
`ifdef PRIV_THR_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic       rclk = 1'b0, arst_l = 1'b0;
  logic [3:0] thr_f = '0, flush_ack = '0;
  logic       fetch_vld_f = 1'b0, tlu_wr_vld = 1'b0;
  logic [1:0] tlu_wr_tid = '0, tlu_wr_level = '0;
  logic       priv_mode_s, hpriv_mode_s, fetch_vld_s, thr_sel_err;
  logic [3:0] flush_req;
  logic [7:0] thr_level_q;

  // Three-thread instance so an out-of-range tid is expressible.
  logic [2:0] b_thr = '0, b_ack = '0;
  logic       b_wv = 1'b0;
  logic [1:0] b_tid = '0, b_wl = '0;
  logic       b_priv, b_hpriv, b_fvs, b_err;
  logic [2:0] b_fl;
  logic [5:0] b_lv;

  int n_tests = 0, n_fail = 0;

  always #5 rclk = ~rclk;

  sparc_ifu_thr_priv_trk #(.NUM_THR(4), .RST_LEVEL(2'b10)) dut (
    .rclk(rclk), .arst_l(arst_l), .thr_f(thr_f), .fetch_vld_f(fetch_vld_f),
    .tlu_wr_vld(tlu_wr_vld), .tlu_wr_tid(tlu_wr_tid), .tlu_wr_level(tlu_wr_level),
    .flush_ack(flush_ack), .priv_mode_s(priv_mode_s), .hpriv_mode_s(hpriv_mode_s),
    .fetch_vld_s(fetch_vld_s), .flush_req(flush_req), .thr_level_q(thr_level_q),
    .thr_sel_err(thr_sel_err));

  sparc_ifu_thr_priv_trk #(.NUM_THR(3), .RST_LEVEL(2'b10)) dut3 (
    .rclk(rclk), .arst_l(arst_l), .thr_f(b_thr), .fetch_vld_f(1'b0),
    .tlu_wr_vld(b_wv), .tlu_wr_tid(b_tid), .tlu_wr_level(b_wl),
    .flush_ack(b_ack), .priv_mode_s(b_priv), .hpriv_mode_s(b_hpriv),
    .fetch_vld_s(b_fvs), .flush_req(b_fl), .thr_level_q(b_lv),
    .thr_sel_err(b_err));

  typedef struct {
    logic [3:0] thr; logic fv; logic wv; logic [1:0] tid; logic [1:0] wl; logic [3:0] ack;
    logic priv; logic hpriv; logic fvs; logic [3:0] fl; logic [7:0] lv;
  } vec_t;
  vec_t tbl[13];

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  task automatic drive(input logic [3:0] thr, input logic fv, input logic wv,
                       input logic [1:0] tid, input logic [1:0] wl, input logic [3:0] ack);
    thr_f = thr; fetch_vld_f = fv; tlu_wr_vld = wv;
    tlu_wr_tid = tid; tlu_wr_level = wl; flush_ack = ack;
    @(posedge rclk); #1;
  endtask

  // Reference model: plain per-thread level and flushing flags.
  int mlvl[4];
  bit mfl[4];
  bit merr;

  task automatic model_reset();
    for (int t = 0; t < 4; t++) begin mlvl[t] = 2; mfl[t] = 0; end
    merr = 0;
  endtask

  task automatic rand_cycle(input int cyc);
    logic [3:0] thr, ack; logic fv, wv; logic [1:0] tid, wl;
    int sel, nl[4], r, L, ones;
    bit acc, low, e_priv, e_hpriv, e_fvs, multi;
    logic [3:0] e_fl; logic [7:0] e_lv;
    r = $urandom_range(0, 9);
    thr = (r < 6) ? 4'(1 << (r % 4)) : (r == 6 ? 4'b0 : 4'($urandom_range(0, 15)));
    fv  = ($urandom_range(0, 3) != 0);
    wv  = $urandom_range(0, 1);
    tid = 2'($urandom_range(0, 3));
    wl  = 2'($urandom_range(0, 3));
    ack = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
    sel = -1; ones = 0;
    for (int t = 3; t >= 0; t--) if (thr[t]) begin sel = t; ones++; end
    multi = CHK && fv && (ones > 1);
    acc = wv && (wl != 2'b11);
    low = acc && (int'(wl) < mlvl[tid]);
    for (int t = 0; t < 4; t++) nl[t] = mlvl[t];
    if (acc) nl[tid] = int'(wl);
    e_priv = 0; e_hpriv = 0; e_fvs = 0;
    if (fv && sel >= 0 && !multi) begin
      L = nl[sel];
      e_priv = (L >= 1); e_hpriv = (L == 2);
      e_fvs = !(mfl[sel] || (low && int'(tid) == sel));
    end
    for (int t = 0; t < 4; t++) begin
      if (low && int'(tid) == t) mfl[t] = 1;
      else if (ack[t]) mfl[t] = 0;
      mlvl[t] = nl[t];
      e_fl[t] = mfl[t];
      e_lv[2*t +: 2] = 2'(mlvl[t]);
    end
    merr = merr || multi;
    drive(thr, fv, wv, tid, wl, ack);
    chk($sformatf("rand%0d", cyc),
        {15'b0, priv_mode_s, hpriv_mode_s, fetch_vld_s, thr_sel_err, flush_req, thr_level_q},
        {15'b0, e_priv, e_hpriv, e_fvs, merr, e_fl, e_lv});
  endtask

  initial begin
    tbl[0]  = '{4'h1, 1, 0, 0, 0, 4'h0, 1, 1, 1, 4'h0, 8'haa};
    tbl[1]  = '{4'h0, 0, 1, 1, 0, 4'h0, 0, 0, 0, 4'h2, 8'ha2};
    tbl[2]  = '{4'h2, 1, 0, 0, 0, 4'h0, 0, 0, 0, 4'h2, 8'ha2};
    tbl[3]  = '{4'h2, 1, 0, 0, 0, 4'h2, 0, 0, 0, 4'h0, 8'ha2};
    tbl[4]  = '{4'h2, 1, 0, 0, 0, 4'h0, 0, 0, 1, 4'h0, 8'ha2};
    tbl[5]  = '{4'h4, 1, 1, 2, 1, 4'h0, 1, 0, 0, 4'h4, 8'h92};
    tbl[6]  = '{4'h1, 1, 0, 0, 0, 4'h4, 1, 1, 1, 4'h0, 8'h92};
    tbl[7]  = '{4'h0, 0, 1, 0, 1, 4'h0, 0, 0, 0, 4'h1, 8'h91};
    tbl[8]  = '{4'h0, 0, 1, 0, 0, 4'h1, 0, 0, 0, 4'h1, 8'h90};
    tbl[9]  = '{4'h0, 0, 0, 0, 0, 4'h1, 0, 0, 0, 4'h0, 8'h90};
    tbl[10] = '{4'h0, 0, 1, 3, 3, 4'h4, 0, 0, 0, 4'h0, 8'h90};
    tbl[11] = '{4'h2, 1, 1, 1, 2, 4'h0, 1, 1, 1, 4'h0, 8'h98};
    tbl[12] = '{4'h3, 1, 0, 0, 0, 4'h0, 0, 0, !CHK, 4'h0, 8'h98};

    #12;
    chk("rst_out", {priv_mode_s, hpriv_mode_s, fetch_vld_s, thr_sel_err, flush_req}, 8'h0);
    chk("rst_lvl", thr_level_q, 8'haa);
    arst_l = 1'b1;

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].thr, tbl[i].fv, tbl[i].wv, tbl[i].tid, tbl[i].wl, tbl[i].ack);
      chk($sformatf("vec%0d_s", i), {priv_mode_s, hpriv_mode_s, fetch_vld_s},
          {tbl[i].priv, tbl[i].hpriv, tbl[i].fvs});
      chk($sformatf("vec%0d_fl", i), flush_req, tbl[i].fl);
      chk($sformatf("vec%0d_lv", i), thr_level_q, tbl[i].lv);
    end
    chk("sel_err", thr_sel_err, CHK);

    // Out-of-range tid on the 3-thread instance is dropped; in-range lowering flushes.
    b_wv = 1; b_tid = 2'd3; b_wl = 2'b00;
    @(posedge rclk); #1;
    chk("tid_oob_lv", b_lv, 6'h2a);
    chk("tid_oob_fl", b_fl, 3'h0);
    b_tid = 2'd2;
    @(posedge rclk); #1;
    b_wv = 0;
    chk("tid2_lv", b_lv, 6'h0a);
    chk("tid2_fl", b_fl, 3'h4);

    // Reset while flushes are pending clears them without any ack.
    drive(4'h0, 0, 1, 3, 0, 4'h0);
    chk("pre_rst_fl", flush_req, 4'h8);
    #2 arst_l = 1'b0;
    #1;
    chk("mid_rst_fl", flush_req, 4'h0);
    chk("mid_rst_lv", thr_level_q, 8'haa);
    chk("mid_rst_b", {b_fl, b_lv}, {3'h0, 6'h2a});
    chk("mid_rst_out", {priv_mode_s, hpriv_mode_s, fetch_vld_s, thr_sel_err}, 4'h0);
    #1 arst_l = 1'b1;
    drive(4'h8, 1, 0, 0, 0, 4'h0);
    chk("post_rst", {priv_mode_s, hpriv_mode_s, fetch_vld_s, flush_req}, {3'b111, 4'h0});

    model_reset();
    for (int c = 0; c < 600; c++) rand_cycle(c);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
